// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the radix-2 DIF FFT datapath: the stage
//   sequencer state encoding and the default transform size / butterfly
//   pipeline depth used by the controller, the datapath top and the
//   twiddle ROM.
// ---------------------------------------------------------------------------
package fft_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } fft_state_t;

  // log2 of the transform size
  localparam int FFT_LOGN   = 4;
  // cycles the butterfly adds after the synchronous memory read
  localparam int FFT_PE_LAT = 1;

endpackage

// File: rtl/fft_addr_gen.sv
// ---------------------------------------------------------------------------
// fft_addr_gen
//   Combinational operand-address and twiddle-index generator for one
//   butterfly of an in-place radix-2 DIF FFT.
//
//   Ports:
//     i_stage      stage index s, 0..LOGN-1
//     i_bf         butterfly index within the stage, 0..N/2-1
//     o_rd_addr_a  upper operand address  (grp*2*span + pos)
//     o_rd_addr_b  lower operand address  (upper + span)
//     o_tw_idx     twiddle exponent k of W_N^k (pos << s, truncated)
//     o_tw_en      high when the twiddle is not the trivial W_N^0
// ---------------------------------------------------------------------------
module fft_addr_gen
  import fft_pkg::*;
#(
  parameter int LOGN = FFT_LOGN,
  parameter int SW   = 2
) (
  input  logic [SW-1:0]   i_stage,
  input  logic [LOGN-2:0] i_bf,
  output logic [LOGN-1:0] o_rd_addr_a,
  output logic [LOGN-1:0] o_rd_addr_b,
  output logic [LOGN-2:0] o_tw_idx,
  output logic            o_tw_en
);

  logic [LOGN-1:0] w_bf;
  logic [LOGN-1:0] w_span;
  logic [LOGN-1:0] w_pos;
  logic [LOGN-1:0] w_grp;
  logic [LOGN-1:0] w_addr_a;
  logic [LOGN-2:0] w_tw;
  logic [31:0]     w_shr;
  logic [31:0]     w_shl;

  always_comb begin
    w_bf   = {1'b0, i_bf};
    // span = N >> (s+1) = 1 << (LOGN-1-s); a group occupies 2*span = N >> s
    w_shr  = 32'(LOGN - 1) - 32'(i_stage);
    w_shl  = 32'(LOGN) - 32'(i_stage);
    w_span = LOGN'(1) << w_shr;
    w_pos  = w_bf & (w_span - LOGN'(1));
    w_grp  = w_bf >> w_shr;
    // pos < span, so the group base and offset never overlap: OR == add
    w_addr_a = (w_grp << w_shl) | w_pos;
    w_tw     = (LOGN-1)'(w_pos << i_stage);

    o_rd_addr_a = w_addr_a;
    o_rd_addr_b = w_addr_a | w_span;
    o_tw_idx    = w_tw;
    o_tw_en     = (w_tw != '0);
  end

endmodule

// File: rtl/fft_stage_ctrl.sv
// ---------------------------------------------------------------------------
// fft_stage_ctrl
//   Stage sequencer for an in-place radix-2 DIF FFT built around a single
//   butterfly. Issues one butterfly read per cycle, inserts a D-cycle drain
//   gap after every stage so no stage reads a location still being written,
//   and replays each read address D cycles later as the write-back address.
//
//   Ports:
//     clk, rst              clock (rising edge), async active-high reset
//     start                 request one full transform, sampled in IDLE
//     busy                  high while the transform is in progress
//     done                  one-cycle pulse after the final write
//     stage                 current stage index
//     rd_en, rd_addr_a/b    data memory read strobe and operand addresses
//     tw_idx, tw_en         twiddle ROM index and butterfly twiddle enable
//     wr_en, wr_addr_a/b    write strobe and addresses (read delayed by D)
//   All outputs are registered and clear to 0 on reset.
// ---------------------------------------------------------------------------
module fft_stage_ctrl
  import fft_pkg::*;
#(
  parameter int LOGN   = FFT_LOGN,
  parameter int PE_LAT = FFT_PE_LAT,
  parameter int SW     = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic            busy,
  output logic            done,
  output logic [SW-1:0]   stage,
  output logic            rd_en,
  output logic [LOGN-1:0] rd_addr_a,
  output logic [LOGN-1:0] rd_addr_b,
  output logic [LOGN-2:0] tw_idx,
  output logic            tw_en,
  output logic            wr_en,
  output logic [LOGN-1:0] wr_addr_a,
  output logic [LOGN-1:0] wr_addr_b
);

  localparam int D   = PE_LAT + 1;
  localparam int NH  = 1 << (LOGN - 1);
  localparam int DCW = (D > 1) ? $clog2(D) : 1;

  localparam logic [LOGN-2:0] BF_LAST    = (LOGN-1)'(NH - 1);
  localparam logic [SW-1:0]   STAGE_LAST = SW'(LOGN - 1);
  localparam logic [DCW-1:0]  DCNT_LAST  = DCW'(D - 1);

  fft_state_t      r_state,  w_state_nxt;
  logic [SW-1:0]   r_stage,  w_stage_nxt;
  logic [LOGN-2:0] r_bf,     w_bf_nxt;
  logic [DCW-1:0]  r_dcnt,   w_dcnt_nxt;

  logic [LOGN-1:0] w_addr_a;
  logic [LOGN-1:0] w_addr_b;
  logic [LOGN-2:0] w_tw_idx;
  logic            w_tw_en;
  logic            w_run;

  logic [D-1:0]    r_wr_en_pipe;
  logic [LOGN-1:0] r_wr_a_pipe [D];
  logic [LOGN-1:0] r_wr_b_pipe [D];

  fft_addr_gen #(
    .LOGN (LOGN),
    .SW   (SW)
  ) u_addr_gen (
    .i_stage     (r_stage),
    .i_bf        (r_bf),
    .o_rd_addr_a (w_addr_a),
    .o_rd_addr_b (w_addr_b),
    .o_tw_idx    (w_tw_idx),
    .o_tw_en     (w_tw_en)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_stage <= '0;
      r_bf    <= '0;
      r_dcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_stage <= w_stage_nxt;
      r_bf    <= w_bf_nxt;
      r_dcnt  <= w_dcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stage_nxt = r_stage;
    w_bf_nxt    = r_bf;
    w_dcnt_nxt  = r_dcnt;
    w_run       = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_nxt = ST_RUN;
          w_stage_nxt = '0;
          w_bf_nxt    = '0;
        end
      end
      ST_RUN: begin
        w_run = 1'b1;
        // bf holds at its last value; it is only cleared when the next
        // stage begins
        if (r_bf == BF_LAST) begin
          w_state_nxt = ST_DRAIN;
          w_dcnt_nxt  = '0;
        end else begin
          w_bf_nxt = r_bf + 1'b1;
        end
      end
      ST_DRAIN: begin
        w_dcnt_nxt = r_dcnt + 1'b1;
        if (r_dcnt == DCNT_LAST) begin
          if (r_stage == STAGE_LAST) begin
            w_state_nxt = ST_DONE;
          end else begin
            w_state_nxt = ST_RUN;
            w_stage_nxt = r_stage + 1'b1;
            w_bf_nxt    = '0;
          end
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Read-side output register: address, twiddle and strobe share a cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      stage     <= '0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_idx    <= '0;
      tw_en     <= 1'b0;
    end else begin
      busy      <= (r_state == ST_RUN) || (r_state == ST_DRAIN);
      done      <= (r_state == ST_DONE);
      stage     <= r_stage;
      rd_en     <= w_run;
      rd_addr_a <= w_run ? w_addr_a : '0;
      rd_addr_b <= w_run ? w_addr_b : '0;
      tw_idx    <= w_run ? w_tw_idx : '0;
      tw_en     <= w_run & w_tw_en;
    end
  end

  // Write-back delay pipeline: D register stages behind the read outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en_pipe <= '0;
      for (int i = 0; i < D; i++) begin
        r_wr_a_pipe[i] <= '0;
        r_wr_b_pipe[i] <= '0;
      end
    end else begin
      r_wr_en_pipe[0] <= rd_en;
      r_wr_a_pipe[0]  <= rd_addr_a;
      r_wr_b_pipe[0]  <= rd_addr_b;
      for (int i = 1; i < D; i++) begin
        r_wr_en_pipe[i] <= r_wr_en_pipe[i-1];
        r_wr_a_pipe[i]  <= r_wr_a_pipe[i-1];
        r_wr_b_pipe[i]  <= r_wr_b_pipe[i-1];
      end
    end
  end

  assign wr_en     = r_wr_en_pipe[D-1];
  assign wr_addr_a = r_wr_a_pipe[D-1];
  assign wr_addr_b = r_wr_b_pipe[D-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_stage_ctrl
//   Scoreboard bench for fft_stage_ctrl (LOGN=4, PE_LAT=1). The expected
//   butterfly trace of a whole transform is queued when start is accepted
//   and popped as the controller issues reads and writes.
// ---------------------------------------------------------------------------
module tb_fft_stage_ctrl;

  localparam int LOGN   = 4;
  localparam int PE_LAT = 1;
  localparam int SW     = 2;
  localparam int D      = PE_LAT + 1;
  localparam int NH     = 1 << (LOGN - 1);
  localparam int PERIOD = NH + D;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic            busy;
  logic            done;
  logic [SW-1:0]   stage;
  logic            rd_en;
  logic [LOGN-1:0] rd_addr_a;
  logic [LOGN-1:0] rd_addr_b;
  logic [LOGN-2:0] tw_idx;
  logic            tw_en;
  logic            wr_en;
  logic [LOGN-1:0] wr_addr_a;
  logic [LOGN-1:0] wr_addr_b;

  always #5 clk = ~clk;

  fft_stage_ctrl #(
    .LOGN   (LOGN),
    .PE_LAT (PE_LAT),
    .SW     (SW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .stage     (stage),
    .rd_en     (rd_en),
    .rd_addr_a (rd_addr_a),
    .rd_addr_b (rd_addr_b),
    .tw_idx    (tw_idx),
    .tw_en     (tw_en),
    .wr_en     (wr_en),
    .wr_addr_a (wr_addr_a),
    .wr_addr_b (wr_addr_b)
  );

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] tw;
    logic       twen;
    logic [1:0] st;
  } rec_t;

  rec_t rdq[$];
  rec_t wrq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int base  = -100000;
  int nrd   = 0;
  int nwr   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h at cycle %0d (rel %0d)", tag, got, exp, cyc, cyc - base);
    end
  endtask

  function automatic logic m_rd(input int r);
    for (int s = 0; s < LOGN; s++)
      if (r >= 1 + s*PERIOD && r <= NH + s*PERIOD) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic m_busy(input int r);
    return (r >= 1) && (r <= LOGN*PERIOD);
  endfunction

  function automatic logic m_done(input int r);
    return (r == LOGN*PERIOD + 1);
  endfunction

  function automatic logic [31:0] all_outs();
    return {6'd0, busy, done, stage, rd_en, rd_addr_a, rd_addr_b,
            tw_idx, tw_en, wr_en, wr_addr_a, wr_addr_b};
  endfunction

  // Expected trace built group by group rather than from the bf index
  task automatic push_expected();
    rec_t e;
    int   span;
    for (int s = 0; s < LOGN; s++) begin
      span = NH >> s;
      for (int g = 0; g < (1 << s); g++) begin
        for (int p = 0; p < span; p++) begin
          e.a    = 4'(g*2*span + p);
          e.b    = 4'(g*2*span + p + span);
          e.tw   = 3'(p << s);
          e.twen = (e.tw != 3'd0);
          e.st   = 2'(s);
          rdq.push_back(e);
          wrq.push_back(e);
        end
      end
    end
  endtask

  task automatic check_cycle();
    int   r;
    rec_t e;
    r = cyc - base;
    chk("rd_en", 32'(rd_en), 32'(m_rd(r)));
    chk("wr_en", 32'(wr_en), 32'(m_rd(r - D)));
    chk("busy",  32'(busy),  32'(m_busy(r)));
    chk("done",  32'(done),  32'(m_done(r)));
    if (rd_en) begin
      nrd++;
      if (rdq.size() == 0) chk("rd_extra", 32'd1, 32'd0);
      else begin
        e = rdq.pop_front();
        chk("rd_addr_a", 32'(rd_addr_a), 32'(e.a));
        chk("rd_addr_b", 32'(rd_addr_b), 32'(e.b));
        chk("tw_idx",    32'(tw_idx),    32'(e.tw));
        chk("tw_en",     32'(tw_en),     32'(e.twen));
        chk("stage",     32'(stage),     32'(e.st));
      end
    end
    if (wr_en) begin
      nwr++;
      if (wrq.size() == 0) chk("wr_extra", 32'd1, 32'd0);
      else begin
        e = wrq.pop_front();
        chk("wr_addr_a", 32'(wr_addr_a), 32'(e.a));
        chk("wr_addr_b", 32'(wr_addr_b), 32'(e.b));
      end
    end
    if (rd_en && wr_en)
      chk("rw_hazard", 32'((rd_addr_a == wr_addr_a) || (rd_addr_a == wr_addr_b) ||
                           (rd_addr_b == wr_addr_a) || (rd_addr_b == wr_addr_b)), 32'd0);
    if (m_done(r)) begin
      chk("n_reads",  32'(nrd), 32'(LOGN*NH));
      chk("n_writes", 32'(nwr), 32'(LOGN*NH));
    end
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    #1;
    check_cycle();
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk);
    cyc++;
    base = cyc;
    nrd  = 0;
    nwr  = 0;
    push_expected();
    #1;
    start = 1'b0;
    check_cycle();
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #1;
    chk("reset_outs", all_outs(), 32'd0);
    step();
    step();
    rst = 1'b0;
    step();
    step();

    // First transform, with a start pulse mid-run and one on the done cycle
    do_start();
    while (cyc - base < 4) step();
    start = 1'b1;
    step();
    start = 1'b0;
    while (cyc - base < LOGN*PERIOD) step();
    start = 1'b1;
    step();
    // start still high: accepted in the IDLE cycle after done
    chk("second_start_cycle", 32'(cyc - base), 32'(LOGN*PERIOD + 1));
    do_start();
    while (cyc - base < LOGN*PERIOD + 8) step();
    chk("rdq_left", 32'(rdq.size()), 32'd0);
    chk("wrq_left", 32'(wrq.size()), 32'd0);

    // Asynchronous reset in the middle of stage 1
    do_start();
    while (cyc - base < 15) step();
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outs", all_outs(), 32'd0);
    rdq.delete();
    wrq.delete();
    base = -100000;
    step();
    rst = 1'b0;
    repeat (10) step();

    // Restart after reset must begin at stage 0, bf 0
    do_start();
    while (cyc - base < LOGN*PERIOD + 4) step();
    chk("rdq_left_end", 32'(rdq.size()), 32'd0);
    chk("wrq_left_end", 32'(wrq.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
- Sequencer for an in-place, radix-2 decimation-in-frequency FFT built around the single `pe` butterfly.
- Generates the operand read addresses, twiddle index, twiddle-enable (the `pe` `en` input) and delayed write-back addresses for every butterfly of every stage.
- Inserts drain gaps between stages so no read-after-write hazard exists on the data memory.
- Sits between the top-level start/done handshake and the data memory, twiddle ROM and `pe`.

Parameters:
- LOGN, 4, log2 of FFT size; N = 2^LOGN points, N/2 butterflies per stage, LOGN stages.
- PE_LAT, 1, pipeline cycles the datapath adds after the 1-cycle synchronous memory read.
- SW, 2, width of the stage output; must satisfy 2^SW >= LOGN.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request one full FFT; sampled only in IDLE.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse after the final write.
- stage  out  SW  current stage index, 0..LOGN-1.
- rd_en  out  1  data memory read strobe.
- rd_addr_a  out  LOGN  upper operand address.
- rd_addr_b  out  LOGN  lower operand address.
- tw_idx  out  LOGN-1  twiddle ROM index k (W_N^k).
- tw_en  out  1  drives `pe` en; 1 = apply twiddle multiply.
- wr_en  out  1  data memory write strobe.
- wr_addr_a  out  LOGN  write address for result a.
- wr_addr_b  out  LOGN  write address for result b.

Behaviour:
- All outputs are registered. Reset value of every output is 0.
- Reset is asynchronous: it clears the FSM, all counters and the write-delay pipeline. Any in-flight writes are discarded.
- D = PE_LAT + 1.
- States and transitions:
  - IDLE -> RUN on start.
  - RUN: bf counts 0..N/2-1, one butterfly per cycle. At bf = N/2-1 go to DRAIN.
  - DRAIN: count D cycles with rd_en = 0. Then, if stage < LOGN-1, increment stage, clear bf and go to RUN; otherwise go to DONE.
  - DONE: done = 1 for one cycle, busy = 0, go to IDLE.
- Address generation for stage s and butterfly bf:
  - span = N >> (s+1)
  - pos = bf mod span
  - grp = bf >> (LOGN-1-s)
  - rd_addr_a = grp*2*span + pos
  - rd_addr_b = rd_addr_a + span
  - tw_idx = pos << s, truncated to LOGN-1 bits
  - tw_en = (tw_idx != 0)
- rd_en, rd_addr_*, tw_idx and tw_en are valid in the same cycle.
- wr_en and wr_addr_a/b equal rd_en and rd_addr_a/b delayed by exactly D cycles, through a shift pipeline.
- Timing, with start accepted at edge E0:
  - Stage s reads at cycles 1 + s*(N/2+D) through N/2 + s*(N/2+D).
  - done is asserted at cycle LOGN*(N/2+D) + 1.
- start while busy is ignored, with no queuing.
- start on the same cycle as the done pulse is ignored; it is accepted in the following IDLE cycle.
- Counters never wrap mid-stage: bf resets only on the DRAIN->RUN transition.

Decomposition:
- Shared package fft_pkg holds:
  - the state enum (IDLE, RUN, DRAIN, DONE);
  - default LOGN and PE_LAT constants, reused by the datapath top and the twiddle ROM.
- One sub-module, fft_addr_gen: stage and bf in; rd_addr_a, rd_addr_b, tw_idx and tw_en out. Combinational; the controller registers its outputs.
- The FSM, counters and write-delay pipeline stay in fft_stage_ctrl.

Test Plan (LOGN=4, PE_LAT=1, so D=2):
- Reset: assert rst mid-RUN -> all outputs 0 that cycle, wr_en stays 0 afterwards; the next start restarts at stage 0, bf 0.
- Stage 0: start at E0 -> cycle 1: rd_addr a=0, b=8, tw_idx=0, tw_en=0; cycle 2: a=1, b=9, tw_idx=1, tw_en=1; cycle 8: a=7, b=15, tw_idx=7.
- Stage 1 (reads cycles 11..18) -> bf 0: a=0, b=4, tw=0; bf 3: a=3, b=7, tw=6; bf 4: a=8, b=12, tw=0. Stage 3 (cycles 31..38) -> bf k: a=2k, b=2k+1, tw_en=0.
- Write delay: every wr_en/wr_addr equals rd_en/rd_addr from 2 cycles earlier. No write address is read in the same cycle across a stage boundary.
- Completion: done pulses exactly at cycle 41, busy falls the same cycle; 4 DRAIN gaps of 2 cycles each; total reads = 32, total writes = 32.
- Handshake: pulse start at cycles 5 and 41 -> both ignored; start at cycle 42 -> second FFT with identical address trace offset by 42.
